// File: rtl/serial_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared definitions for the serial bit shifter and the 1101
//                sequence detector: shifter state codes, default word width
//                and the idle line level.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_pkg;

    // Shifter state codes
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Default parallel word width
    localparam int C_DEFAULT_WIDTH = 8;

    // Level held on the serial line whenever no word is being shifted
    localparam logic C_IDLE_BIT = 1'b0;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serial_bit_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : serial_bit_shifter
//  Description : Parallel-to-serial converter. Accepts WIDTH-bit words on a
//                valid/ready handshake and emits them one bit per clock on
//                sout, back-to-back without gap bits. sout rests at IDLE_BIT
//                when no word is active.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_bit_shifter
    import serial_pkg::*;
#(
    parameter int   WIDTH     = C_DEFAULT_WIDTH,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = C_IDLE_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             last_bit
);

    localparam int             CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]  C_CNT_LAST = CW'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   w_shreg_nxt;
    logic [WIDTH-1:0]   w_shreg_shifted;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               w_shifting;
    logic               w_last;
    logic               w_accept;
    logic               w_out_bit;

    // Bit ordering: which end of the shift register faces the line, and the
    // direction the register moves to bring the next bit there.
    if (MSB_FIRST) begin : g_msb_first
        assign w_out_bit       = r_shreg[WIDTH-1];
        assign w_shreg_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
        assign w_out_bit       = r_shreg[0];
        assign w_shreg_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end

    // Output decode is purely from registers so the detector sees a clean line.
    assign w_shifting = (r_state == ST_SHIFT);
    assign w_last     = w_shifting && (r_cnt == C_CNT_LAST);
    assign busy       = w_shifting;
    assign sout_valid = w_shifting;
    assign last_bit   = w_last;
    assign din_ready  = !w_shifting || w_last;
    assign w_accept   = din_valid && din_ready;
    assign sout       = w_shifting ? w_out_bit : IDLE_BIT;

    // Next-state logic: load on accept (also during the final bit, giving
    // gapless streaming), otherwise shift or fall back to idle.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        if (w_accept) begin
            w_shreg_nxt = din;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_SHIFT;
        end else if (w_shifting) begin
            if (w_last) begin
                w_state_nxt = ST_IDLE;
            end else begin
                w_shreg_nxt = w_shreg_shifted;
                w_cnt_nxt   = r_cnt + 1'b1;
            end
        end
    end

    // State, shift register and bit counter; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule : serial_bit_shifter
`default_nettype wire

// File: tb/tb_serial_bit_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_serial_bit_shifter
//  Description : Scoreboard bench for serial_bit_shifter. Three instances
//                (8-bit MSB-first, 8-bit LSB-first, 2-bit MSB-first with
//                idle level 1) are driven with directed and random words.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_bit_shifter;

    localparam int   WA [3] = '{8, 8, 2};
    localparam bit   MA [3] = '{1'b1, 1'b0, 1'b1};
    localparam logic IA [3] = '{1'b0, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din [3];
    logic       vld [3];
    logic       rdy [3];
    logic       so  [3];
    logic       sov [3];
    logic       bsy [3];
    logic       lb  [3];

    int tests = 0;
    int fails = 0;
    bit armed = 1'b0;

    // Expected line contents per instance: {last_flag, bit}, front = on sout now
    logic [1:0] q [3][$];

    always #5 clk = ~clk;

    serial_bit_shifter #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_a (
        .clk(clk), .rst(rst), .din(din[0]), .din_valid(vld[0]), .din_ready(rdy[0]),
        .sout(so[0]), .sout_valid(sov[0]), .busy(bsy[0]), .last_bit(lb[0]));

    serial_bit_shifter #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_b (
        .clk(clk), .rst(rst), .din(din[1]), .din_valid(vld[1]), .din_ready(rdy[1]),
        .sout(so[1]), .sout_valid(sov[1]), .busy(bsy[1]), .last_bit(lb[1]));

    serial_bit_shifter #(.WIDTH(2), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_c (
        .clk(clk), .rst(rst), .din(din[2][1:0]), .din_valid(vld[2]), .din_ready(rdy[2]),
        .sout(so[2]), .sout_valid(sov[2]), .busy(bsy[2]), .last_bit(lb[2]));

    task automatic chk(input string name, input int k, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d @%0t: got %b expected %b", name, k, $time, act, exp);
        end
    endtask

    // Monitor/scoreboard: compares the line against the expected bit stream,
    // then records a new word whenever a handshake will occur at the next edge.
    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                logic [1:0] e;
                logic       have;
                have = (q[k].size() > 0);
                chk("sout_valid", k, sov[k], have);
                chk("busy", k, bsy[k], have);
                if (have) begin
                    e = q[k].pop_front();
                    chk("sout", k, so[k], e[0]);
                    chk("last_bit", k, lb[k], e[1]);
                    chk("din_ready", k, rdy[k], e[1]);
                end else begin
                    chk("sout_idle", k, so[k], IA[k]);
                    chk("last_bit_idle", k, lb[k], 1'b0);
                    chk("din_ready_idle", k, rdy[k], 1'b1);
                end
                if (rst) begin
                    q[k].delete();
                end else if (vld[k] && rdy[k]) begin
                    for (int i = 0; i < WA[k]; i++) begin
                        logic b;
                        b = MA[k] ? din[k][WA[k]-1-i] : din[k][i];
                        q[k].push_back({(i == WA[k]-1), b});
                    end
                end
            end
        end
    end

    // Offer a word until it is taken. With jam set, din is scrambled during
    // the cycles where the block is not ready. With hold set, valid stays up.
    task automatic send(input int k, input logic [7:0] w, input bit hold, input bit jam);
        bit done;
        done = 1'b0;
        vld[k] = 1'b1;
        din[k] = w;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            #1;
            if (rdy[k]) begin
                done = 1'b1;
                @(posedge clk);
                #1;
                if (!hold) vld[k] = 1'b0;
            end else if (jam) begin
                din[k] = 8'($urandom);
                @(posedge clk);
                #1;
                din[k] = w;
            end
        end
        if (!done) begin
            fails++;
            $display("FAIL handshake_timeout inst%0d: got no din_ready expected din_ready within 200 cycles", k);
            vld[k] = 1'b0;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0;
            din[k] = 8'h00;
        end
        @(posedge clk);
        #1 armed = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle_cycles(10);

        // Single word, then back-to-back pair, then backpressure with jammed din
        send(0, 8'hD0, 1'b0, 1'b0);
        idle_cycles(12);
        send(0, 8'hA5, 1'b1, 1'b0);
        send(0, 8'h3C, 1'b0, 1'b0);
        idle_cycles(12);
        send(0, 8'h5A, 1'b0, 1'b0);
        send(0, 8'h96, 1'b0, 1'b1);
        idle_cycles(12);

        // Reset in the middle of a word, then a clean word
        send(0, 8'hFF, 1'b0, 1'b0);
        idle_cycles(2);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        idle_cycles(2);
        send(0, 8'h0F, 1'b0, 1'b0);
        idle_cycles(12);

        // Valid coincident with reset must not be accepted
        vld[0] = 1'b1;
        din[0] = 8'h77;
        rst    = 1'b1;
        idle_cycles(1);
        rst    = 1'b0;
        vld[0] = 1'b0;
        idle_cycles(3);

        // LSB-first and minimum width
        send(1, 8'h0B, 1'b0, 1'b0);
        send(2, 8'h02, 1'b0, 1'b0);
        idle_cycles(12);

        // Random traffic on all instances concurrently
        fork
            for (int n = 0; n < 40; n++) begin
                int g;
                g = $urandom_range(0, 3);
                send(0, 8'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
                if (g != 0) begin vld[0] = 1'b0; idle_cycles(g); end
            end
            for (int n = 0; n < 40; n++) begin
                int g;
                g = $urandom_range(0, 3);
                send(1, 8'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
                if (g != 0) begin vld[1] = 1'b0; idle_cycles(g); end
            end
            for (int n = 0; n < 60; n++) begin
                int g;
                g = $urandom_range(0, 2);
                send(2, 8'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
                if (g != 0) begin vld[2] = 1'b0; idle_cycles(g); end
            end
        join
        for (int k = 0; k < 3; k++) vld[k] = 1'b0;
        idle_cycles(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_serial_bit_shifter
`default_nettype wire

// File: doc/serial_bit_shifter.md
Name: serial_bit_shifter

Overview:
Parallel-to-serial converter that sits directly upstream of the team's 1101 Moore sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on sout. The detector samples its input on every clock and has no qualifier, so sout is held at a defined idle level whenever no word is being shifted. Back-to-back words stream with no gap bits.

Parameters:
WIDTH, 8, word width in bits; legal range WIDTH >= 2.
MSB_FIRST, 1, 1 = din[WIDTH-1] is sent first; 0 = din[0] is sent first.
IDLE_BIT, 0, level driven on sout while no word is active.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  reset, synchronous, active-high.
din  input  WIDTH  parallel word; must be stable while din_valid=1 and din_ready=0.
din_valid  input  1  upstream has a word on din.
din_ready  output  1  block will accept din on this edge.
sout  output  1  serial bit; connects to the detector's data input.
sout_valid  output  1  sout carries a data bit this cycle.
busy  output  1  a word is being shifted (state SHIFT).
last_bit  output  1  sout carries the final bit of the current word.

Behaviour:
- Internal state: state (IDLE, SHIFT), shift register shreg[WIDTH-1:0], bit counter cnt of width $clog2(WIDTH).
- Reset (rst=1 at an edge) gives: state=IDLE, shreg=0, cnt=0.
- Outputs after reset: sout=IDLE_BIT, sout_valid=0, busy=0, last_bit=0, din_ready=1.
- Reset has priority over every other event.
- Output decode, all from registers only:
  - busy = sout_valid = (state==SHIFT).
  - last_bit = (state==SHIFT && cnt==WIDTH-1).
  - din_ready = (state==IDLE) || last_bit.
  - sout = IDLE_BIT in IDLE; in SHIFT, shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
- Accept: a word is accepted on an edge where din_valid && din_ready. On accept: shreg<=din, cnt<=0, state<=SHIFT.
- IDLE, no accept: hold all state.
- SHIFT with cnt<WIDTH-1:
  - shreg shifts by one toward the output end: left if MSB_FIRST, else right.
  - 0 is shifted in at the vacated end.
  - cnt increments.
  - din_valid is ignored (din_ready=0); nothing is stored.
- SHIFT with cnt==WIDTH-1:
  - If accept: reload as above and stay in SHIFT. There is no idle bit between words.
  - Otherwise: state<=IDLE.
- Latency: for a word accepted at edge k, bit i (i=0..WIDTH-1, in transmit order) is on sout in the cycle after edge k+i. The first bit appears one cycle after accept. sout_valid stays high for exactly WIDTH cycles per word.
- Reset mid-word: the partial word is discarded. sout returns to IDLE_BIT after the reset edge. No resume.
- din_valid and rst high on the same edge: reset wins, and the word is not accepted.
- The block never drops or duplicates an accepted word. The upstream source owns holding din until accepted.

Decomposition:
- Shared package serial_pkg, containing:
  - state codes ST_IDLE=1'b0 and ST_SHIFT=1'b1;
  - the default word width;
  - the idle level constant. The detector bench uses the same constant.
- No sub-module. The counter and shifter are small enough to stay inline.
- Integration wrapper (separate file): serial_bit_shifter.sout drives the detector's serial input; both share clk and rst.

Test Plan:
- Reset then idle: rst for 2 cycles, din_valid=0 for 10 cycles -> sout=0, sout_valid=0, busy=0, din_ready=1 throughout.
- Single word, MSB first: din=8'hD0 accepted at edge k -> sout=1,1,0,1,0,0,0,0 in cycles k+1..k+8. last_bit is high only in cycle k+8. Idle afterwards. The attached detector out pulses once, one cycle after the 4th bit's cycle.
- Back-to-back: din_valid held high with 8'hA5, switched to 8'h3C on the handshake -> 16 contiguous valid bits 10100101 00111100. din_ready is high in IDLE and in each last_bit cycle only. busy never drops between the words.
- Backpressure: din_valid=1 with din changing during SHIFT (din_ready=0) -> none of those values appear on sout. Only the value present at the handshake edge is sent.
- Reset mid-word: rst asserted after 3 bits of 8'hFF -> sout=0, sout_valid=0 on the next cycle. The next accepted word 8'h0F is sent complete and correct.
- LSB first: MSB_FIRST=0, din=8'h0B -> sout=1,1,0,1,0,0,0,0. WIDTH=2 with din=2'b10 and MSB_FIRST=1 -> sout=1,0, last_bit high in the 2nd bit cycle.
